// File: rtl/load_store_unit.sv
// Load/store sequencer between the core execute stage and a single-port word memory.
// Splits word-crossing accesses into two memory cycles and handles lane shifting and extension.
module load_store_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_address,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  input  logic [31:0] read_memory_data,
  output logic [31:0] read_memory_address,
  output logic [31:0] write_memory_data,
  output logic [31:0] write_memory_address,
  output logic [31:0] write_memory_mask,
  output logic        memory_write_enable
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD0, S_RD1, S_RWAIT, S_WR0, S_WR1, S_RESP
  } state_e;

  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    case (sz)
      2'd0:    return 3'd1;
      2'd1:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [31:0] byte_mask(input logic [2:0] nb);
    case (nb)
      3'd1:    return 32'h0000_00FF;
      3'd2:    return 32'h0000_FFFF;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  // Selects the 32 bits starting at byte offset o of the 64-bit pair {hi,lo}.
  function automatic logic [31:0] lane_select(input logic [31:0] hi, input logic [31:0] lo,
                                              input logic [1:0] o);
    case (o)
      2'd0:    return lo;
      2'd1:    return {hi[7:0],  lo[31:8]};
      2'd2:    return {hi[15:0], lo[31:16]};
      default: return {hi[23:0], lo[31:24]};
    endcase
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] r, input logic [2:0] nb,
                                         input logic uns);
    case (nb)
      3'd1:    return {{24{~uns & r[7]}},  r[7:0]};
      3'd2:    return {{16{~uns & r[15]}}, r[15:0]};
      default: return r;
    endcase
  endfunction

  state_e      state_q, state_d;
  logic [31:0] lo_q, lo_d, hi_d;
  logic [1:0]  off_q, off_d;
  logic [2:0]  nb_q, nb_d;
  logic        cross_q, cross_d;
  logic        uns_q, uns_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] lword_q, lword_d;
  logic [63:0] wd64, wm64;

  logic        req_ready_q, req_ready_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] raddr_q, raddr_d;
  logic        we_q, we_d;
  logic [31:0] waddr_q, waddr_d;
  logic [31:0] wdo_q, wdo_d;
  logic [31:0] wmask_q, wmask_d;

  always_comb begin
    state_d = state_q;
    lo_d    = lo_q;
    off_d   = off_q;
    nb_d    = nb_q;
    cross_d = cross_q;
    uns_d   = uns_q;
    wdata_d = wdata_q;
    lword_d = lword_q;
    rdata_d = rdata_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          lo_d    = {req_address[31:2], 2'b00};
          off_d   = req_address[1:0];
          nb_d    = size_bytes(req_size);
          cross_d = ({1'b0, req_address[1:0]} + size_bytes(req_size)) > 3'd4;
          uns_d   = req_unsigned;
          wdata_d = req_wdata;
          state_d = req_write ? S_WR0 : S_RD0;
        end
      end
      S_RD0:   state_d = cross_q ? S_RD1 : S_RWAIT;
      S_RD1: begin
        lword_d = read_memory_data;
        state_d = S_RWAIT;
      end
      S_RWAIT: begin
        if (cross_q)
          rdata_d = extend(lane_select(read_memory_data, lword_q, off_q), nb_q, uns_q);
        else
          rdata_d = extend(lane_select(32'h0, read_memory_data, off_q), nb_q, uns_q);
        state_d = S_RESP;
      end
      // Store responses present zero read data.
      S_WR0: begin
        if (cross_q) begin
          state_d = S_WR1;
        end else begin
          rdata_d = 32'h0;
          state_d = S_RESP;
        end
      end
      S_WR1: begin
        rdata_d = 32'h0;
        state_d = S_RESP;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered: derive the values for the state being entered.
    hi_d         = lo_d + 32'd4;
    wd64         = {32'h0, wdata_d} << {off_d, 3'b000};
    wm64         = {32'h0, byte_mask(nb_d)} << {off_d, 3'b000};
    req_ready_d  = (state_d == S_IDLE);
    resp_valid_d = (state_d == S_RESP);
    raddr_d      = 32'h0;
    we_d         = 1'b0;
    waddr_d      = 32'h0;
    wdo_d        = 32'h0;
    wmask_d      = 32'h0;
    case (state_d)
      S_RD0: raddr_d = lo_d;
      S_RD1: raddr_d = hi_d;
      S_WR0: begin
        we_d    = 1'b1;
        waddr_d = lo_d;
        wdo_d   = wd64[31:0];
        wmask_d = wm64[31:0];
      end
      S_WR1: begin
        we_d    = 1'b1;
        waddr_d = hi_d;
        wdo_d   = wd64[63:32];
        wmask_d = wm64[63:32];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      rdata_q      <= 32'h0;
      raddr_q      <= 32'h0;
      we_q         <= 1'b0;
      waddr_q      <= 32'h0;
      wdo_q        <= 32'h0;
      wmask_q      <= 32'h0;
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      rdata_q      <= rdata_d;
      raddr_q      <= raddr_d;
      we_q         <= we_d;
      waddr_q      <= waddr_d;
      wdo_q        <= wdo_d;
      wmask_q      <= wmask_d;
    end
  end

  // Request fields are only consumed under state control, so they need no reset.
  always_ff @(posedge clk) begin
    lo_q    <= lo_d;
    off_q   <= off_d;
    nb_q    <= nb_d;
    cross_q <= cross_d;
    uns_q   <= uns_d;
    wdata_q <= wdata_d;
    lword_q <= lword_d;
  end

  assign req_ready            = req_ready_q;
  assign resp_valid           = resp_valid_q;
  assign resp_rdata           = rdata_q;
  assign read_memory_address  = raddr_q;
  assign memory_write_enable  = we_q;
  assign write_memory_address = waddr_q;
  assign write_memory_data    = wdo_q;
  assign write_memory_mask    = wmask_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small synchronous word memory model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_address = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [31:0] read_memory_data;
  logic [31:0] read_memory_address;
  logic [31:0] write_memory_data;
  logic [31:0] write_memory_address;
  logic [31:0] write_memory_mask;
  logic        memory_write_enable;

  logic [31:0] mem [0:15];
  logic [31:0] rd_q = 32'h0;
  logic        poke_en = 1'b0;
  logic [3:0]  poke_idx = 4'd0;
  logic [31:0] poke_val = 32'h0;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk                  (clk),
    .reset                (reset),
    .req_valid            (req_valid),
    .req_ready            (req_ready),
    .req_write            (req_write),
    .req_size             (req_size),
    .req_unsigned         (req_unsigned),
    .req_address          (req_address),
    .req_wdata            (req_wdata),
    .resp_valid           (resp_valid),
    .resp_rdata           (resp_rdata),
    .read_memory_data     (read_memory_data),
    .read_memory_address  (read_memory_address),
    .write_memory_data    (write_memory_data),
    .write_memory_address (write_memory_address),
    .write_memory_mask    (write_memory_mask),
    .memory_write_enable  (memory_write_enable)
  );

  // Memory window 0x80000000..0x8000003C, one-cycle read, bit-masked write.
  assign read_memory_data = rd_q;
  always @(posedge clk) begin
    if (poke_en)
      mem[poke_idx] <= poke_val;
    else if (memory_write_enable)
      mem[write_memory_address[5:2]] <= (mem[write_memory_address[5:2]] & ~write_memory_mask)
                                        | (write_memory_data & write_memory_mask);
    if (!memory_write_enable)
      rd_q <= mem[read_memory_address[5:2]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [3:0] idx, input logic [31:0] val);
    poke_en = 1'b1; poke_idx = idx; poke_val = val;
    tick();
    poke_en = 1'b0;
  endtask

  // Issues one request from idle; returns cycles to resp_valid (0 on timeout),
  // the response data and the read address seen in the first two busy cycles.
  task automatic do_req(input logic w, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output int lat, output logic [31:0] rdata,
                        output logic [31:0] ra0, output logic [31:0] ra1);
    req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = uns;
    req_address = addr; req_wdata = wd;
    tick();
    req_valid = 1'b0;
    lat = 0; ra0 = read_memory_address; ra1 = 32'h0;
    for (int i = 1; i <= 8; i++) begin
      if (i == 2) ra1 = read_memory_address;
      if (resp_valid) begin
        lat = i;
        break;
      end
      tick();
    end
    rdata = resp_rdata;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          lat;
    int          pulses;
    logic [31:0] rd, ra0, ra1;

    for (int i = 0; i < 16; i++) poke(4'(i), 32'h0);
    chk("rst_ready", {31'h0, req_ready}, 32'h1);
    chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rst_we", {31'h0, memory_write_enable}, 32'h0);
    chk("rst_raddr", read_memory_address, 32'h0);
    reset = 1'b1;
    tick();

    // 1: aligned word load
    poke(4'd0, 32'h1122_3344);
    poke(4'd1, 32'h0000_80FF);
    do_req(1'b0, 2'd2, 1'b0, 32'h8000_0000, 32'h0, lat, rd, ra0, ra1);
    chk("t1_lat", lat, 3);
    chk("t1_rdata", rd, 32'h1122_3344);
    chk("t1_raddr", ra0, 32'h8000_0000);
    chk("t1_raddr_rwait", ra1, 32'h0);

    // 2: sub-word loads with extension
    do_req(1'b0, 2'd0, 1'b0, 32'h8000_0005, 32'h0, lat, rd, ra0, ra1);
    chk("t2_sbyte", rd, 32'hFFFF_FF80);
    chk("t2_sbyte_raddr", ra0, 32'h8000_0004);
    do_req(1'b0, 2'd1, 1'b1, 32'h8000_0004, 32'h0, lat, rd, ra0, ra1);
    chk("t2_uhalf", rd, 32'h0000_80FF);
    do_req(1'b0, 2'd1, 1'b0, 32'h8000_0004, 32'h0, lat, rd, ra0, ra1);
    chk("t2_shalf", rd, 32'hFFFF_80FF);

    // 3: word-crossing load
    poke(4'd0, 32'hAABB_CCDD);
    poke(4'd1, 32'h1122_3344);
    do_req(1'b0, 2'd2, 1'b0, 32'h8000_0002, 32'h0, lat, rd, ra0, ra1);
    chk("t3_lat", lat, 4);
    chk("t3_raddr_lo", ra0, 32'h8000_0000);
    chk("t3_raddr_hi", ra1, 32'h8000_0004);
    chk("t3_rdata", rd, 32'h3344_AABB);

    // 4: word-crossing half store, cycle by cycle
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd1; req_unsigned = 1'b0;
    req_address = 32'h8000_0003; req_wdata = 32'h0000_BEEF;
    tick();
    req_valid = 1'b0;
    chk("t4_wr0_we", {31'h0, memory_write_enable}, 32'h1);
    chk("t4_wr0_addr", write_memory_address, 32'h8000_0000);
    chk("t4_wr0_mask", write_memory_mask, 32'hFF00_0000);
    chk("t4_wr0_data", write_memory_data, 32'hEF00_0000);
    chk("t4_wr0_ready", {31'h0, req_ready}, 32'h0);
    tick();
    chk("t4_wr1_we", {31'h0, memory_write_enable}, 32'h1);
    chk("t4_wr1_addr", write_memory_address, 32'h8000_0004);
    chk("t4_wr1_mask", write_memory_mask, 32'h0000_00FF);
    chk("t4_wr1_data", write_memory_data, 32'h0000_00BE);
    tick();
    chk("t4_resp_valid", {31'h0, resp_valid}, 32'h1);
    chk("t4_resp_rdata", resp_rdata, 32'h0);
    chk("t4_resp_we", {31'h0, memory_write_enable}, 32'h0);
    chk("t4_resp_waddr", write_memory_address, 32'h0);
    tick();
    do_req(1'b0, 2'd2, 1'b0, 32'h8000_0000, 32'h0, lat, rd, ra0, ra1);
    chk("t4_rb_lo", rd, 32'hEFBB_CCDD);
    do_req(1'b0, 2'd2, 1'b0, 32'h8000_0004, 32'h0, lat, rd, ra0, ra1);
    chk("t4_rb_hi", rd, 32'h1122_33BE);

    // aligned byte store: latency and masking of unused wdata bytes
    do_req(1'b1, 2'd0, 1'b0, 32'h8000_0009, 32'hFFFF_FF5A, lat, rd, ra0, ra1);
    chk("sb_lat", lat, 2);
    do_req(1'b0, 2'd0, 1'b1, 32'h8000_0009, 32'h0, lat, rd, ra0, ra1);
    chk("sb_ubyte", rd, 32'h0000_005A);
    do_req(1'b0, 2'd2, 1'b0, 32'h8000_0008, 32'h0, lat, rd, ra0, ra1);
    chk("sb_word", rd, 32'h0000_5A00);

    // 5: req_valid held across two loads; fields changed while busy
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_unsigned = 1'b1;
    req_address = 32'h8000_0000;
    tick();
    chk("t5_c1_ready", {31'h0, req_ready}, 32'h0);
    req_address = 32'h8000_0004;
    tick();
    chk("t5_c2_ready", {31'h0, req_ready}, 32'h0);
    tick();
    chk("t5_c3_resp", {31'h0, resp_valid}, 32'h1);
    chk("t5_c3_rdata", resp_rdata, 32'hEFBB_CCDD);
    chk("t5_c3_ready", {31'h0, req_ready}, 32'h0);
    tick();
    chk("t5_c4_ready", {31'h0, req_ready}, 32'h1);
    chk("t5_c4_resp", {31'h0, resp_valid}, 32'h0);
    tick();
    req_valid = 1'b0;
    chk("t5_c5_ready", {31'h0, req_ready}, 32'h0);
    chk("t5_c5_raddr", read_memory_address, 32'h8000_0004);
    tick();
    tick();
    chk("t5_c7_resp", {31'h0, resp_valid}, 32'h1);
    chk("t5_c7_rdata", resp_rdata, 32'h1122_33BE);
    tick();

    // 6: reset asserted during WR1 of a crossing store
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2;
    req_address = 32'h8000_0006; req_wdata = 32'h5566_7788;
    tick();
    req_valid = 1'b0;
    chk("t6_wr0_mask", write_memory_mask, 32'hFFFF_0000);
    chk("t6_wr0_data", write_memory_data, 32'h7788_0000);
    tick();
    chk("t6_wr1_we", {31'h0, memory_write_enable}, 32'h1);
    chk("t6_wr1_addr", write_memory_address, 32'h8000_0008);
    chk("t6_wr1_data", write_memory_data, 32'h0000_5566);
    #1 reset = 1'b0;
    #1;
    chk("t6_rst_we", {31'h0, memory_write_enable}, 32'h0);
    chk("t6_rst_waddr", write_memory_address, 32'h0);
    chk("t6_rst_wmask", write_memory_mask, 32'h0);
    chk("t6_rst_wdata", write_memory_data, 32'h0);
    chk("t6_rst_ready", {31'h0, req_ready}, 32'h1);
    tick();
    tick();
    reset = 1'b1;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      if (resp_valid) pulses++;
      tick();
    end
    chk("t6_no_resp", pulses, 0);
    chk("t6_ready_after", {31'h0, req_ready}, 32'h1);
    chk("t6_mem_hi_untouched", mem[2], 32'h0000_5A00);
    chk("t6_mem_lo_written", mem[1], 32'h7788_33BE);
    do_req(1'b0, 2'd2, 1'b0, 32'h8000_0004, 32'h0, lat, rd, ra0, ra1);
    chk("t6_post_lat", lat, 3);
    chk("t6_post_rdata", rd, 32'h7788_33BE);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
